// File: rtl/lsu_dmem_master_if.sv
// ---------------------------------------------------------------------------
// lsu_dmem_master_if: core-side request/response and data-memory bus signals
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lsu_dmem_master_if;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic        lsu_err;
  logic [31:0] lsu_rdata;
  logic        data_wren;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data_in;
  logic [31:0] dmem_data_out;

  modport master (
    input  lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, dmem_data_out,
    output lsu_busy, lsu_done, lsu_err, lsu_rdata, data_wren, dmem_addr, dmem_data_in
  );

  modport slave (
    output lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, dmem_data_out,
    input  lsu_busy, lsu_done, lsu_err, lsu_rdata, data_wren, dmem_addr, dmem_data_in
  );
endinterface

`default_nettype wire

// File: rtl/lsu_dmem_master.sv
// ---------------------------------------------------------------------------
// lsu_dmem_master: RV32I byte/half/word load-store unit with RMW sub-word stores
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_dmem_master #(
  parameter int DMEM_WORDS  = 1024,
  parameter bit CHECK_RANGE = 1'b1
) (
  input logic               clk,
  input logic               rst,
  lsu_dmem_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        wren_q;

  logic        req_illegal;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_error;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  // Request qualification works on the live inputs so the error path reaches DONE in one cycle.
  always_comb begin
    if (bus.lsu_we) begin
      req_illegal = (bus.lsu_funct3 > 3'd2);
    end else begin
      req_illegal = (bus.lsu_funct3 == 3'd3) || (bus.lsu_funct3[2:1] == 2'b11);
    end
    case (bus.lsu_funct3[1:0])
      2'd1:    req_misaligned = bus.lsu_addr[0];
      2'd2:    req_misaligned = (bus.lsu_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
    req_out_of_range = CHECK_RANGE &&
                       ({2'b00, bus.lsu_addr[31:2]} >= $unsigned(DMEM_WORDS));
    req_error = req_illegal || req_misaligned || req_out_of_range;
  end

  always_comb begin
    ld_byte = bus.dmem_data_out[{addr_q[1:0], 3'b000} +: 8];
    ld_half = bus.dmem_data_out[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    load_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    load_val = {{16{ld_half[15]}}, ld_half};
      3'd4:    load_val = {24'd0, ld_byte};
      3'd5:    load_val = {16'd0, ld_half};
      default: load_val = bus.dmem_data_out;
    endcase
  end

  always_comb begin
    merge_val = bus.dmem_data_out;
    if (funct3_q[0]) begin
      merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      merge_q  <= 32'd0;
      rdata_q  <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wren_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.lsu_req) begin
            funct3_q <= bus.lsu_funct3;
            addr_q   <= bus.lsu_addr;
            wdata_q  <= bus.lsu_wdata;
            busy_q   <= 1'b1;
            if (req_error) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (!bus.lsu_we) begin
              state <= LOAD;
            end else if (bus.lsu_funct3[1:0] == 2'd2) begin
              state  <= WRITE;
              wren_q <= 1'b1;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_val;
          done_q  <= 1'b1;
          state   <= DONE;
        end
        RMW_RD: begin
          merge_q <= merge_val;
          wren_q  <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          wren_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          wren_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.lsu_busy     = busy_q;
  assign bus.lsu_done     = done_q;
  assign bus.lsu_err      = err_q;
  assign bus.lsu_rdata    = rdata_q;
  // Gating with rst keeps a reset that lands in WRITE from committing the word.
  assign bus.data_wren    = wren_q & ~rst;
  assign bus.dmem_addr    = {addr_q[31:2], 2'b00};
  assign bus.dmem_data_in = (funct3_q[1:0] == 2'd2) ? wdata_q : merge_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_dmem_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_dmem_master: directed and randomized checks against a behavioural LSU model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wev = 1'b0;
  logic [2:0]  f3v = 3'd0;
  logic [31:0] addrv = 32'd0;
  logic [31:0] wdv = 32'd0;

  int checks = 0;
  int failures = 0;

  bit [31:0] mem0 [1024];
  bit [31:0] mem1 [1024];
  bit [31:0] ref_mem [1024];
  int        wr_count = 0;
  logic [31:0] last_wa = 32'd0;
  bit [31:0] exp_rdata = 32'd0;

  always #5 clk = ~clk;

  lsu_dmem_master_if bus0 ();
  lsu_dmem_master_if bus1 ();

  assign bus0.lsu_req = req;     assign bus1.lsu_req = req;
  assign bus0.lsu_we = wev;      assign bus1.lsu_we = wev;
  assign bus0.lsu_funct3 = f3v;  assign bus1.lsu_funct3 = f3v;
  assign bus0.lsu_addr = addrv;  assign bus1.lsu_addr = addrv;
  assign bus0.lsu_wdata = wdv;   assign bus1.lsu_wdata = wdv;
  assign bus0.dmem_data_out = mem0[bus0.dmem_addr[11:2]];
  assign bus1.dmem_data_out = mem1[bus1.dmem_addr[11:2]];

  lsu_dmem_master #(.DMEM_WORDS(1024), .CHECK_RANGE(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus0));
  lsu_dmem_master #(.DMEM_WORDS(1024), .CHECK_RANGE(1'b0)) dut_nr (.clk(clk), .rst(rst), .bus(bus1));

  // Data memories: combinational read, word write on posedge.
  always @(posedge clk) begin
    if (bus0.data_wren) begin
      mem0[bus0.dmem_addr[11:2]] <= bus0.dmem_data_in;
      wr_count <= wr_count + 1;
      last_wa  <= bus0.dmem_addr;
    end
    if (bus1.data_wren) mem1[bus1.dmem_addr[11:2]] <= bus1.dmem_data_in;
  end

  function automatic bit ref_err(bit we, bit [2:0] f3, bit [31:0] a, bit rng);
    bit ill, mis, oor;
    int size;
    ill  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    size = 1 << f3[1:0];
    mis  = (a % size) != 0;
    oor  = rng && ((a / 4) >= 1024);
    return ill || mis || oor;
  endfunction

  function automatic int ref_lat(bit we, bit [2:0] f3, bit [31:0] a, bit rng);
    if (ref_err(we, f3, a, rng)) return 1;
    if (!we || f3 == 3'd2) return 2;
    return 3;
  endfunction

  function automatic bit [31:0] ref_load(bit [31:0] w, bit [2:0] f3, bit [31:0] a);
    bit [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic bit [31:0] ref_store(bit [31:0] w, bit [2:0] f3, bit [31:0] a, bit [31:0] wd);
    bit [31:0] mask;
    int sh;
    case (f3)
      3'd0: begin
        sh = 8 * (a % 4);
        mask = 32'hFF << sh;
        return (w & ~mask) | ((wd & 32'hFF) << sh);
      end
      3'd1: begin
        sh = 16 * ((a / 2) % 2);
        mask = 32'hFFFF << sh;
        return (w & ~mask) | ((wd & 32'hFFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  function automatic void model_apply(bit we, bit [2:0] f3, bit [31:0] a, bit [31:0] wd);
    int idx;
    if (ref_err(we, f3, a, 1'b1)) return;
    idx = int'(a / 4);
    if (we) ref_mem[idx] = ref_store(ref_mem[idx], f3, a, wd);
    else    exp_rdata = ref_load(ref_mem[idx], f3, a);
  endfunction

  // Issue one request and observe both DUTs; optionally pulse lsu_req while busy.
  task automatic do_op(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                       input bit pulse, output int lat0, output bit e0, output bit [31:0] rd0,
                       output int lat1, output bit e1, output int nw, output bit [31:0] wa,
                       output bit proto_ok);
    int w_start;
    lat0 = 0; lat1 = 0; e0 = 1'b0; e1 = 1'b0; rd0 = 32'd0; proto_ok = 1'b1;
    @(negedge clk);
    req = 1'b1; wev = we; f3v = f3; addrv = a; wdv = wd;
    w_start = wr_count;
    @(posedge clk);
    for (int k = 1; k <= 8 && (lat0 == 0 || lat1 == 0); k++) begin
      @(negedge clk);
      req = pulse && (k == 1);
      if (bus0.lsu_done) begin
        if (lat0 == 0) begin
          lat0 = k; e0 = bus0.lsu_err; rd0 = bus0.lsu_rdata;
        end else begin
          proto_ok = 1'b0;
        end
      end else if (bus0.lsu_err) begin
        proto_ok = 1'b0;
      end
      if (lat0 == 0 && !bus0.lsu_busy) proto_ok = 1'b0;
      if (bus1.lsu_done && lat1 == 0) begin
        lat1 = k; e1 = bus1.lsu_err;
      end
    end
    @(negedge clk);
    req = 1'b0;
    if (bus0.lsu_busy || bus0.lsu_done || bus0.lsu_err) proto_ok = 1'b0;
    nw = wr_count - w_start;
    wa = last_wa;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus0.lsu_busy, bus0.lsu_done, bus0.lsu_err, bus0.data_wren} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {bus0.lsu_busy, bus0.lsu_done, bus0.lsu_err, bus0.data_wren});
    end
    checks++;
    if ({bus0.lsu_rdata, bus0.dmem_addr, bus0.dmem_data_in} !== 96'd0) begin
      failures++;
      $display("FAIL reset_data rdata=%h addr=%h din=%h want=0", bus0.lsu_rdata, bus0.dmem_addr, bus0.dmem_data_in);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus0.lsu_busy, bus0.lsu_done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle got=%b want=00", {bus0.lsu_busy, bus0.lsu_done});
    end
  endtask

  task automatic test_sw_lw();
    int l0, l1, nw; bit e0, e1, ok; bit [31:0] rd, wa;
    do_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, l0, e0, rd, l1, e1, nw, wa, ok);
    model_apply(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    checks++;
    if (l0 != 2 || e0 !== 1'b0) begin
      failures++; $display("FAIL sw_done lat=%0d err=%b want lat=2 err=0", l0, e0);
    end
    checks++;
    if (nw != 1 || wa !== 32'h10) begin
      failures++; $display("FAIL sw_write writes=%0d addr=%h want 1 at 00000010", nw, wa);
    end
    do_op(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, l0, e0, rd, l1, e1, nw, wa, ok);
    model_apply(1'b0, 3'd2, 32'h10, 32'h0);
    checks++;
    if (l0 != 2 || e0 !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL lw_data lat=%0d err=%b rdata=%h want 2/0/deadbeef", l0, e0, rd);
    end
  endtask

  task automatic test_sb_merge();
    int l0, l1, nw; bit e0, e1, ok; bit [31:0] rd, wa;
    do_op(1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, l0, e0, rd, l1, e1, nw, wa, ok);
    model_apply(1'b1, 3'd2, 32'h10, 32'h11223344);
    do_op(1'b1, 3'd0, 32'h12, 32'h5A5A5AAA, 1'b0, l0, e0, rd, l1, e1, nw, wa, ok);
    model_apply(1'b1, 3'd0, 32'h12, 32'h5A5A5AAA);
    checks++;
    if (l0 != 3 || nw != 1) begin
      failures++; $display("FAIL sb_timing lat=%0d writes=%0d want 3/1", l0, nw);
    end
    checks++;
    if (mem0[4] !== 32'h11AA3344) begin
      failures++; $display("FAIL sb_merge word=%h want 11aa3344", mem0[4]);
    end
  endtask

  task automatic test_load_ext();
    int l0, l1, nw; bit e0, e1, ok; bit [31:0] rd, wa;
    bit [31:0] ta[5] = '{32'h21, 32'h22, 32'h23, 32'h22, 32'h22};
    bit [2:0]  tf[5] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5};
    bit [31:0] te[5] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    do_op(1'b1, 3'd2, 32'h20, 32'h80FF7F01, 1'b0, l0, e0, rd, l1, e1, nw, wa, ok);
    model_apply(1'b1, 3'd2, 32'h20, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, tf[i], ta[i], 32'h0, 1'b0, l0, e0, rd, l1, e1, nw, wa, ok);
      model_apply(1'b0, tf[i], ta[i], 32'h0);
      checks++;
      if (rd !== te[i] || l0 != 2 || e0 !== 1'b0) begin
        failures++;
        $display("FAIL load_ext[%0d] f3=%0d addr=%h rdata=%h lat=%0d err=%b want %h/2/0", i, tf[i], ta[i], rd, l0, e0, te[i]);
      end
    end
  endtask

  task automatic test_errors();
    int l0, l1, nw; bit e0, e1, ok; bit [31:0] rd, wa;
    bit        tw[3] = '{1'b0, 1'b1, 1'b0};
    bit [2:0]  tf[3] = '{3'd2, 3'd1, 3'd3};
    bit [31:0] ta[3] = '{32'h06, 32'h03, 32'h10};
    for (int i = 0; i < 3; i++) begin
      do_op(tw[i], tf[i], ta[i], 32'h0000BEEF, 1'b1, l0, e0, rd, l1, e1, nw, wa, ok);
      model_apply(tw[i], tf[i], ta[i], 32'h0000BEEF);
      checks++;
      if (l0 != 1 || e0 !== 1'b1 || nw != 0 || rd !== exp_rdata || !ok) begin
        failures++;
        $display("FAIL err_case[%0d] lat=%0d err=%b writes=%0d rdata=%h proto=%b want 1/1/0/%h/1", i, l0, e0, nw, rd, ok, exp_rdata);
      end
    end
    checks++;
    if (mem0[0] !== ref_mem[0] || mem0[1] !== ref_mem[1] || mem0[4] !== ref_mem[4]) begin
      failures++; $display("FAIL err_mem w0=%h w1=%h w4=%h want %h %h %h", mem0[0], mem0[1], mem0[4], ref_mem[0], ref_mem[1], ref_mem[4]);
    end
  endtask

  task automatic test_range();
    int l0, l1, nw; bit e0, e1, ok; bit [31:0] rd, wa;
    do_op(1'b0, 3'd2, 32'h1000, 32'h0, 1'b0, l0, e0, rd, l1, e1, nw, wa, ok);
    checks++;
    if (l0 != 1 || e0 !== 1'b1) begin
      failures++; $display("FAIL range_on lat=%0d err=%b want 1/1", l0, e0);
    end
    checks++;
    if (l1 != 2 || e1 !== 1'b0) begin
      failures++; $display("FAIL range_off lat=%0d err=%b want 2/0", l1, e1);
    end
  endtask

  task automatic test_rst_in_write();
    int l0, l1, nw, w_start; bit e0, e1, ok; bit [31:0] rd, wa;
    do_op(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, 1'b0, l0, e0, rd, l1, e1, nw, wa, ok);
    model_apply(1'b1, 3'd2, 32'h30, 32'hCAFEF00D);
    @(negedge clk);
    req = 1'b1; wev = 1'b1; f3v = 3'd1; addrv = 32'h32; wdv = 32'h0000BEEF;
    w_start = wr_count;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus0.lsu_busy !== 1'b1) begin
      failures++; $display("FAIL rst_busy got=%b want=1", bus0.lsu_busy);
    end
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (bus0.data_wren !== 1'b1) begin
      failures++; $display("FAIL rst_pre_wren got=%b want=1", bus0.data_wren);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus0.data_wren !== 1'b0) begin
      failures++; $display("FAIL rst_wren_gate got=%b want=0", bus0.data_wren);
    end
    @(negedge clk);
    checks++;
    if ({bus0.lsu_busy, bus0.lsu_done, bus0.lsu_err, bus0.data_wren} !== 4'b0 ||
        {bus0.lsu_rdata, bus0.dmem_addr, bus0.dmem_data_in} !== 96'd0) begin
      failures++;
      $display("FAIL rst_outputs flags=%b rdata=%h addr=%h din=%h want all 0",
               {bus0.lsu_busy, bus0.lsu_done, bus0.lsu_err, bus0.data_wren}, bus0.lsu_rdata, bus0.dmem_addr, bus0.dmem_data_in);
    end
    rst = 1'b0;
    exp_rdata = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus0.lsu_done !== 1'b0 || bus0.lsu_busy !== 1'b0 || wr_count != w_start || mem0[12] !== ref_mem[12]) begin
      failures++;
      $display("FAIL rst_no_write done=%b busy=%b writes=%0d word=%h want 0/0/0/%h",
               bus0.lsu_done, bus0.lsu_busy, wr_count - w_start, mem0[12], ref_mem[12]);
    end
  endtask

  task automatic test_random();
    int l0, l1, nw, el0, el1, idx, size; bit e0, e1, ok, ee0, ee1, we, pulse; bit [31:0] rd, wa, a, wd;
    bit [2:0] f3;
    bit [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = ld_f3[$urandom_range(0, 4)];
      a = $urandom_range(0, 255);
      size = 1 << f3[1:0];
      if ($urandom_range(0, 9) < 7) a = a - (a % size);
      if ($urandom_range(0, 9) == 0) a = a + 32'h1000 * $urandom_range(1, 1000);
      wd = $urandom;
      pulse = 1'($urandom_range(0, 1));
      ee0 = ref_err(we, f3, a, 1'b1);
      ee1 = ref_err(we, f3, a, 1'b0);
      el0 = ref_lat(we, f3, a, 1'b1);
      el1 = ref_lat(we, f3, a, 1'b0);
      do_op(we, f3, a, wd, pulse, l0, e0, rd, l1, e1, nw, wa, ok);
      model_apply(we, f3, a, wd);
      checks++;
      if (l0 != el0 || e0 !== ee0 || rd !== exp_rdata) begin
        failures++;
        $display("FAIL rnd[%0d] we=%b f3=%0d a=%h lat=%0d err=%b rdata=%h want %0d/%b/%h", n, we, f3, a, l0, e0, rd, el0, ee0, exp_rdata);
      end
      checks++;
      if (nw != ((we && !ee0) ? 1 : 0) || (we && !ee0 && wa !== {a[31:2], 2'b00})) begin
        failures++;
        $display("FAIL rnd_write[%0d] writes=%0d addr=%h want %0d at %h", n, nw, wa, (we && !ee0) ? 1 : 0, {a[31:2], 2'b00});
      end
      if (a < 32'h1000) begin
        idx = int'(a / 4);
        checks++;
        if (mem0[idx] !== ref_mem[idx]) begin
          failures++; $display("FAIL rnd_mem[%0d] idx=%0d got=%h want=%h", n, idx, mem0[idx], ref_mem[idx]);
        end
      end
      checks++;
      if (l1 != el1 || e1 !== ee1 || !ok) begin
        failures++;
        $display("FAIL rnd_nr[%0d] lat=%0d err=%b proto=%b want %0d/%b/1", n, l1, e1, ok, el1, ee1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sw_lw();
    test_sb_merge();
    test_load_ext();
    test_errors();
    test_range();
    test_rst_in_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store unit that drives the word-addressed data memory (32-bit x 1024 words, combinational read, word-wide write on posedge clk) on behalf of the core.
- Accepts one byte, halfword or word load/store per request, aligned to RV32I LB/LH/LW/LBU/LHU/SB/SH/SW semantics.
- Performs read-modify-write for sub-word stores, because the memory has only a whole-word write enable.
- Sits between the execute stage and the data memory. Reports completion, load data and error to the core.

Parameters:
- DMEM_WORDS, 1024, number of 32-bit words in the data memory. A word index >= DMEM_WORDS is out of range.
- CHECK_RANGE, 1, when 1 out-of-range accesses raise lsu_err and never reach memory; when 0 no range check is made.

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- lsu_req  in  1  request strobe, sampled only in IDLE
- lsu_we  in  1  1 = store, 0 = load
- lsu_funct3  in  3  RV32I funct3 of the load/store
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data, low byte/half used for SB/SH
- lsu_busy  out  1  high whenever state != IDLE
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  valid with lsu_done: misaligned, illegal funct3 or out-of-range
- lsu_rdata  out  32  extended load result, valid with lsu_done for loads
- data_wren  out  1  memory write enable
- dmem_addr  out  32  byte address to memory, bits [1:0] always 00
- dmem_data_in  out  32  write word to memory
- dmem_data_out  in  32  read word from memory (combinational)

Behaviour:
- Reset values:
  - state = IDLE
  - lsu_busy = 0, lsu_done = 0, lsu_err = 0
  - lsu_rdata = 0
  - data_wren = 0, dmem_addr = 0, dmem_data_in = 0
  - all latched request registers = 0
- States: IDLE, LOAD, RMW_RD, WRITE, DONE.
- IDLE, lsu_req = 1:
  - Latch we, funct3, addr and wdata.
  - Error check:
    - misaligned: half with addr[0] = 1, or word with addr[1:0] != 0
    - illegal funct3: load with funct3 in {3, 6, 7}, or store with funct3 > 2
    - out of range (CHECK_RANGE = 1): addr[31:2] >= DMEM_WORDS
  - On error go to DONE with lsu_err = 1. No memory access; data_wren is never asserted.
  - Otherwise: a load goes to LOAD; SW goes to WRITE; SB or SH goes to RMW_RD.
- IDLE, lsu_req = 0: stay in IDLE.
- Memory address: dmem_addr = {latched addr[31:2], 2'b00} in every non-IDLE state; it holds its last value in IDLE.
- LOAD (1 cycle):
  - Sample dmem_data_out.
  - Select byte addr[1:0] or half addr[1] (little-endian).
  - Extend: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Register the result into lsu_rdata, then go to DONE.
- RMW_RD (1 cycle):
  - Capture dmem_data_out into a merge register.
  - Replace byte lane addr[1:0] (SB) or half lane addr[1] (SH) with lsu_wdata[7:0] / [15:0].
  - Go to WRITE.
- WRITE (1 cycle):
  - data_wren = 1 and dmem_data_in = merged word (SB/SH) or latched wdata (SW).
  - Go to DONE.
- data_wren is asserted only in WRITE and is gated with !rst, so reset during WRITE suppresses the write.
- DONE (1 cycle):
  - lsu_done = 1; lsu_err reflects the request.
  - Go to IDLE.
  - lsu_rdata holds until the next load completes and is not updated for stores or errors.
- lsu_req is ignored while lsu_busy = 1. The core must re-present the request after it sees DONE.
- Latency from the request cycle (N) to lsu_done:
  - load: done in N+2
  - SW: done in N+2, write edge at end of N+1
  - SB/SH: done in N+3
  - error: done in N+1
- Reset in any state returns to IDLE on the next edge. No partial write occurs and no done pulse is issued.
- lsu_err = 0 whenever lsu_done = 0.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 -> data_wren high for one cycle with dmem_addr 0x10; load done at N+2 with lsu_rdata 0xDEADBEEF, lsu_err 0.
- Word 0x10 = 0x11223344, SB addr 0x12, wdata 0xAA -> memory word becomes 0x11AA3344; done at N+3; exactly one data_wren cycle.
- Word 0x20 = 0x80FF7F01:
  - LB 0x21 -> 0x0000007F
  - LB 0x22 -> 0xFFFFFFFF
  - LBU 0x23 -> 0x00000080
  - LH 0x22 -> 0xFFFF80FF
  - LHU 0x22 -> 0x000080FF
- LW 0x06, SH 0x03, and load funct3 = 3 -> each gives done at N+1 with lsu_err 1 and data_wren never high; memory unchanged.
- CHECK_RANGE = 1, LW addr 0x1000 (index 1024) -> lsu_err 1; with CHECK_RANGE = 0 the same access completes with lsu_err 0.
- SH in progress, rst asserted during the WRITE cycle -> no memory write, next state IDLE, lsu_done 0, all outputs at reset values; lsu_req pulsed while busy is ignored (no extra done).
